// File: rtl/final_pkg.sv
// final_pkg: request/function encodings shared by the DTE front-end request executor.
package final_pkg;

    // Front-end request types carried on req_type / rsp_type.
    typedef enum logic [2:0] {
        dteDiagFunc        = 3'd0,
        dteDiagRead        = 3'd1,
        dteDiagWrite       = 3'd2,
        dteReleaseEBUSData = 3'd3,
        dteMisc            = 3'd4
    } tFEReqType;

    // Miscellaneous function codes carried in req_diag for dteMisc.
    typedef enum logic [31:0] {
        clrCROBAR = 32'd0
    } tMiscFuncType;

    // Common KL10 diagnostic function codes (7-bit diag select).
    typedef enum logic [6:0] {
        diagStopClock  = 7'o000,
        diagStartClock = 7'o001,
        diagStepClock  = 7'o002,
        diagCondStep   = 7'o004,
        diagClrReset   = 7'o006,
        diagSetReset   = 7'o007,
        diagClrRunFlop = 7'o010,
        diagSetRunFlop = 7'o011
    } tDiagFunction;

    // Executor sequencing.
    typedef enum logic {
        stIdle    = 1'b0,
        stPending = 1'b1
    } tDteState;

    // Request time meaning "nothing waiting": the request is dropped.
    localparam logic [63:0] NOTHING_WAITING = '1;

endpackage

// File: rtl/final_block.sv
// final_block: DTE front-end request executor.
// Latches one timestamped request, waits for the free-running tick counter to
// reach the request time, then performs the EBUS / CROBAR action and returns a
// one-cycle reply. Optional DTE_TRACE_EN adds a simulation-only trace line per
// executed request; it does not change the logic.
// EBUS data vectors use [DATA_W-1:0] with index DATA_W-1 being PDP-10 bit 0.
module final_block
    import final_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int DS_W   = 7,
    parameter int TICK_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TICK_W-1:0] req_time,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_diag,
    input  logic [63:0]       req_data,
    output logic [DS_W-1:0]   ebus_ds,
    output logic              ebus_strobe,
    output logic              ebus_drive,
    output logic [DATA_W-1:0] ebus_dout,
    input  logic [DATA_W-1:0] ebus_din,
    output logic              rsp_valid,
    output logic [TICK_W-1:0] rsp_ticks,
    output logic [2:0]        rsp_type,
    output logic [31:0]       rsp_diag,
    output logic [63:0]       rsp_data,
    output logic              crobar
);

    tDteState          state_q, state_d;
    logic [TICK_W-1:0] ticks_q, ticks_d;
    logic [TICK_W-1:0] time_q, time_d;
    logic [2:0]        type_q, type_d;
    logic [31:0]       diag_q, diag_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [DS_W-1:0]   ebus_ds_q, ebus_ds_d;
    logic              ebus_strobe_q, ebus_strobe_d;
    logic              ebus_drive_q, ebus_drive_d;
    logic [DATA_W-1:0] ebus_dout_q, ebus_dout_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [TICK_W-1:0] rsp_ticks_q, rsp_ticks_d;
    logic [2:0]        rsp_type_q, rsp_type_d;
    logic [31:0]       rsp_diag_q, rsp_diag_d;
    logic [63:0]       rsp_data_q, rsp_data_d;
    logic              crobar_q, crobar_d;

    logic              execute;
    logic              nothing_waiting;

    // Only the low DATA_W bits of the write data reach the EBUS.
    logic unused_req_data;
    assign unused_req_data = ^req_data[63:DATA_W];

    assign nothing_waiting = (req_time == TICK_W'(NOTHING_WAITING));
    assign execute         = (state_q == stPending) && (ticks_q >= time_q);

    // Next-state, tick counter and registered action/reply computation.
    always_comb begin
        state_d       = state_q;
        ticks_d       = ticks_q + TICK_W'(1);
        time_d        = time_q;
        type_d        = type_q;
        diag_d        = diag_q;
        data_d        = data_q;
        ebus_ds_d     = ebus_ds_q;
        ebus_strobe_d = 1'b0;
        ebus_drive_d  = ebus_drive_q;
        ebus_dout_d   = ebus_dout_q;
        rsp_valid_d   = 1'b0;
        rsp_ticks_d   = rsp_ticks_q;
        rsp_type_d    = rsp_type_q;
        rsp_diag_d    = rsp_diag_q;
        rsp_data_d    = rsp_data_q;
        crobar_d      = crobar_q;

        case (state_q)
            stIdle: begin
                if (req_valid) begin
                    time_d = req_time;
                    type_d = req_type;
                    diag_d = req_diag;
                    data_d = req_data[DATA_W-1:0];
                    if (!nothing_waiting) begin
                        state_d = stPending;
                    end
                end
            end
            stPending: begin
                if (execute) begin
                    state_d     = stIdle;
                    rsp_valid_d = 1'b1;
                    rsp_ticks_d = ticks_q;
                    rsp_type_d  = type_q;
                    rsp_diag_d  = diag_q;
                    rsp_data_d  = {{(64-DATA_W){1'b0}}, ebus_din};
                    case (type_q)
                        dteDiagFunc: begin
                            ebus_ds_d     = diag_q[DS_W-1:0];
                            ebus_strobe_d = 1'b1;
                        end
                        dteDiagWrite: begin
                            ebus_ds_d     = diag_q[DS_W-1:0];
                            ebus_strobe_d = 1'b1;
                            ebus_drive_d  = 1'b1;
                            ebus_dout_d   = data_q;
                        end
                        dteReleaseEBUSData: begin
                            ebus_drive_d = 1'b0;
                            ebus_dout_d  = '0;
                        end
                        dteMisc: begin
                            if (diag_q == clrCROBAR) begin
                                crobar_d = 1'b0;
                            end
                        end
                        default: begin
                            // dteDiagRead and unknown types: reply only.
                        end
                    endcase
                end
            end
            default: state_d = stIdle;
        endcase
    end

    // State, counter and output registers; reset discards any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= stIdle;
            ticks_q       <= '0;
            time_q        <= '0;
            type_q        <= '0;
            diag_q        <= '0;
            data_q        <= '0;
            ebus_ds_q     <= '0;
            ebus_strobe_q <= 1'b0;
            ebus_drive_q  <= 1'b0;
            ebus_dout_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_ticks_q   <= '0;
            rsp_type_q    <= '0;
            rsp_diag_q    <= '0;
            rsp_data_q    <= '0;
            crobar_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            ticks_q       <= ticks_d;
            time_q        <= time_d;
            type_q        <= type_d;
            diag_q        <= diag_d;
            data_q        <= data_d;
            ebus_ds_q     <= ebus_ds_d;
            ebus_strobe_q <= ebus_strobe_d;
            ebus_drive_q  <= ebus_drive_d;
            ebus_dout_q   <= ebus_dout_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ticks_q   <= rsp_ticks_d;
            rsp_type_q    <= rsp_type_d;
            rsp_diag_q    <= rsp_diag_d;
            rsp_data_q    <= rsp_data_d;
            crobar_q      <= crobar_d;
        end
    end

    assign req_ready   = (state_q == stIdle);
    assign ebus_ds     = ebus_ds_q;
    assign ebus_strobe = ebus_strobe_q;
    assign ebus_drive  = ebus_drive_q;
    assign ebus_dout   = ebus_dout_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ticks   = rsp_ticks_q;
    assign rsp_type    = rsp_type_q;
    assign rsp_diag    = rsp_diag_q;
    assign rsp_data    = rsp_data_q;
    assign crobar      = crobar_q;

`ifdef DTE_TRACE_EN
    function automatic string fe_req_name(input logic [2:0] t);
        case (t)
            dteDiagFunc:        return "DiagFunc";
            dteDiagRead:        return "DiagRead";
            dteDiagWrite:       return "DiagWrite";
            dteReleaseEBUSData: return "ReleaseEBUSData";
            dteMisc:            return "Misc";
            default:            return "Unknown";
        endcase
    endfunction

    // Trace each request as it executes; reads show the sampled EBUS data.
    always_ff @(posedge clk) begin
        if (rst_n && execute) begin
            if (type_q == dteDiagRead)
                $display("%0d DTE: %s [%06o,,%06o]", ticks_q, fe_req_name(type_q),
                         ebus_din[DATA_W-1:DATA_W/2], ebus_din[DATA_W/2-1:0]);
            else
                $display("%0d DTE: %s [%06o,,%06o]", ticks_q, fe_req_name(type_q),
                         data_q[DATA_W-1:DATA_W/2], data_q[DATA_W/2-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_final_block.sv
// tb_final_block: directed test of the DTE request executor.
module tb_final_block;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_time;
    logic [2:0]  req_type;
    logic [31:0] req_diag;
    logic [63:0] req_data;
    logic [6:0]  ebus_ds;
    logic        ebus_strobe;
    logic        ebus_drive;
    logic [35:0] ebus_dout;
    logic [35:0] ebus_din;
    logic        rsp_valid;
    logic [63:0] rsp_ticks;
    logic [2:0]  rsp_type;
    logic [31:0] rsp_diag;
    logic [63:0] rsp_data;
    logic        crobar;

    int total = 0;
    int bad   = 0;

    // Reference tick count: equals the DUT tick counter when sampled at negedge.
    logic [63:0] tb_ticks;

    final_block dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_time(req_time), .req_type(req_type), .req_diag(req_diag), .req_data(req_data),
        .ebus_ds(ebus_ds), .ebus_strobe(ebus_strobe), .ebus_drive(ebus_drive),
        .ebus_dout(ebus_dout), .ebus_din(ebus_din),
        .rsp_valid(rsp_valid), .rsp_ticks(rsp_ticks), .rsp_type(rsp_type),
        .rsp_diag(rsp_diag), .rsp_data(rsp_data), .crobar(crobar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ticks <= 64'd0;
        else        tb_ticks <= tb_ticks + 64'd1;
    end

    // Offer one request at the current negedge; returns tick at acceptance edge.
    task automatic send(input logic [63:0] t, input logic [2:0] ty, input logic [31:0] d,
                        input logic [63:0] dat, output logic [63:0] acc_tick);
        acc_tick  = tb_ticks;
        req_valid = 1'b1;
        req_time  = t;
        req_type  = ty;
        req_diag  = d;
        req_data  = dat;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Step negedges until rsp_valid is seen or the budget runs out.
    task automatic wait_rsp(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (crobar !== 1'b1) begin bad++; $display("FAIL reset_crobar got=%b want=1", crobar); end
        total++;
        if (ebus_drive !== 1'b0 || ebus_strobe !== 1'b0 || ebus_dout !== 36'd0 || ebus_ds !== 7'd0) begin
            bad++; $display("FAIL reset_ebus drive=%b strobe=%b dout=%o ds=%o want all 0",
                            ebus_drive, ebus_strobe, ebus_dout, ebus_ds);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_ticks !== 64'd0) begin
            bad++; $display("FAIL reset_rsp valid=%b ticks=%0d want 0/0", rsp_valid, rsp_ticks);
        end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    endtask

    // Non-clear misc code at tick 2 leaves crobar set; clrCROBAR at tick 5 clears it.
    task automatic test_misc;
        logic [63:0] acc;
        bit got;
        int cyc;
        send(64'd2, 3'd4, 32'd3, 64'd0, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || rsp_ticks !== 64'd2 || crobar !== 1'b1) begin
            bad++; $display("FAIL misc_other got=%b ticks=%0d crobar=%b want 1/2/1", got, rsp_ticks, crobar);
        end
        send(64'd5, 3'd4, 32'd0, 64'd0, acc);
        total++;
        if (req_ready !== 1'b0 || crobar !== 1'b1) begin
            bad++; $display("FAIL misc_pending ready=%b crobar=%b want 0/1", req_ready, crobar);
        end
        wait_rsp(20, got, cyc);
        total++;
        if (!got || rsp_ticks !== 64'd5 || rsp_type !== 3'd4 || crobar !== 1'b0 || tb_ticks !== 64'd6) begin
            bad++; $display("FAIL misc_clr got=%b ticks=%0d type=%0d crobar=%b at=%0d want 1/5/4/0/6",
                            got, rsp_ticks, rsp_type, crobar, tb_ticks);
        end
    endtask

    task automatic test_diag_write;
        logic [63:0] acc;
        bit got;
        int cyc;
        send(64'd10, 3'd2, 32'o71, 64'o123456_654321, acc);
        total++;
        if (ebus_strobe !== 1'b0 || ebus_drive !== 1'b0) begin
            bad++; $display("FAIL write_early strobe=%b drive=%b want 0/0", ebus_strobe, ebus_drive);
        end
        wait_rsp(20, got, cyc);
        total++;
        if (!got || rsp_ticks !== 64'd10 || rsp_type !== 3'd2 || rsp_diag !== 32'o71) begin
            bad++; $display("FAIL write_rsp got=%b ticks=%0d type=%0d diag=%o want 1/10/2/71",
                            got, rsp_ticks, rsp_type, rsp_diag);
        end
        total++;
        if (ebus_strobe !== 1'b1 || ebus_ds !== 7'o71 || ebus_drive !== 1'b1 || ebus_dout !== 36'o123456654321) begin
            bad++; $display("FAIL write_ebus strobe=%b ds=%o drive=%b dout=%o want 1/71/1/123456654321",
                            ebus_strobe, ebus_ds, ebus_drive, ebus_dout);
        end
        @(negedge clk);
        total++;
        if (ebus_strobe !== 1'b0 || rsp_valid !== 1'b0 || ebus_drive !== 1'b1 || ebus_ds !== 7'o71) begin
            bad++; $display("FAIL write_after strobe=%b valid=%b drive=%b ds=%o want 0/0/1/71",
                            ebus_strobe, rsp_valid, ebus_drive, ebus_ds);
        end
    endtask

    task automatic test_read_release;
        logic [63:0] acc;
        bit got;
        int cyc;
        ebus_din = 36'o777;
        send(tb_ticks + 64'd3, 3'd1, 32'd0, 64'd0, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || rsp_data !== 64'o777 || rsp_type !== 3'd1 || rsp_ticks !== acc + 64'd3) begin
            bad++; $display("FAIL read_rsp got=%b data=%o type=%0d ticks=%0d want 1/777/1/%0d",
                            got, rsp_data, rsp_type, rsp_ticks, acc + 64'd3);
        end
        total++;
        if (ebus_strobe !== 1'b0 || ebus_drive !== 1'b1 || ebus_dout !== 36'o123456654321) begin
            bad++; $display("FAIL read_ebus strobe=%b drive=%b dout=%o want 0/1/123456654321",
                            ebus_strobe, ebus_drive, ebus_dout);
        end
        send(tb_ticks, 3'd3, 32'd0, 64'd0, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || ebus_drive !== 1'b0 || ebus_dout !== 36'd0 || ebus_ds !== 7'o71) begin
            bad++; $display("FAIL release got=%b drive=%b dout=%o ds=%o want 1/0/0/71",
                            got, ebus_drive, ebus_dout, ebus_ds);
        end
    endtask

    task automatic test_nothing_waiting;
        logic [63:0] acc;
        int seen;
        seen = 0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 32'o12, 64'd0, acc);
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || ebus_strobe) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0 || req_ready !== 1'b1 || ebus_ds !== 7'o71) begin
            bad++; $display("FAIL nothing_waiting pulses=%0d ready=%b ds=%o want 0/1/71", seen, req_ready, ebus_ds);
        end
    endtask

    // Past time executes at the edge after acceptance; then back-to-back DiagFunc and unknown type.
    task automatic test_past_and_back_to_back;
        logic [63:0] acc;
        bit got;
        int cyc;
        while (tb_ticks < 64'd100) @(negedge clk);
        send(64'd3, 3'd0, 32'o15, 64'd0, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || cyc !== 1 || rsp_ticks !== acc + 64'd1 || ebus_ds !== 7'o15 || ebus_strobe !== 1'b1) begin
            bad++; $display("FAIL past_time got=%b cyc=%0d ticks=%0d ds=%o strobe=%b want 1/1/%0d/15/1",
                            got, cyc, rsp_ticks, ebus_ds, ebus_strobe, acc + 64'd1);
        end
        send(64'd0, 3'd0, 32'o42, 64'd0, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || ebus_ds !== 7'o42 || rsp_diag !== 32'o42) begin
            bad++; $display("FAIL back_to_back got=%b ds=%o diag=%o want 1/42/42", got, ebus_ds, rsp_diag);
        end
        send(64'd0, 3'd7, 32'd0, 64'o55, acc);
        wait_rsp(20, got, cyc);
        total++;
        if (!got || rsp_type !== 3'd7 || ebus_strobe !== 1'b0 || ebus_drive !== 1'b0 || crobar !== 1'b0) begin
            bad++; $display("FAIL unknown_type got=%b type=%0d strobe=%b drive=%b crobar=%b want 1/7/0/0/0",
                            got, rsp_type, ebus_strobe, ebus_drive, crobar);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_pulse valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_reset_pending;
        logic [63:0] acc;
        int seen;
        seen = 0;
        send(tb_ticks + 64'd20, 3'd2, 32'o33, 64'o7, acc);
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL pending_ready got=%b want 0", req_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || ebus_drive) seen++;
        end
        total++;
        if (seen !== 0 || crobar !== 1'b1 || req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_pending pulses=%0d crobar=%b ready=%b want 0/1/1", seen, crobar, req_ready);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_time  = 64'd0;
        req_type  = 3'd0;
        req_diag  = 32'd0;
        req_data  = 64'd0;
        ebus_din  = 36'd0;
        test_reset;
        test_misc;
        test_diag_write;
        test_read_release;
        test_nothing_waiting;
        test_past_and_back_to_back;
        test_reset_pending;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
